// File: rtl/omsp_clk_en_gen_if.sv
// Peripheral bus bundle for omsp_clk_en_gen.
// Word-addressed, byte-write bus; per_we == 0 is a read.
interface omsp_clk_en_gen_if;
    logic [7:0]  per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr, per_din, per_en, per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr, per_din, per_en, per_we,
        output per_dout
    );
endinterface

// File: rtl/omsp_clk_en_gen.sv
// Multi-channel clock-enable generator with synchronized POR.
// Define OMSP_CLKGEN_LFXT_EN to build the LFXT source and SEL bit.
module omsp_clk_en_gen #(
    parameter int         NCH       = 2,
    parameter int         CNT_W     = 7,
    parameter logic [8:0] BASE_ADDR = 9'h070,
    parameter int         RST_SYNC  = 2
) (
    input  logic             mclk,
    input  logic             por_reset_a,
    input  logic             lfxt_clk,
    input  logic             oscoff,
    input  logic [NCH-1:0]   gate,
    omsp_clk_en_gen_if.slave per,
    output logic [NCH-1:0]   clk_en,
    output logic             por
);

`ifdef OMSP_CLKGEN_LFXT_EN
    localparam logic [4:0] CTL_MASK = 5'h1f;
`else
    localparam logic [4:0] CTL_MASK = 5'h17;
`endif
    localparam logic [7:0] BASE_W = BASE_ADDR[8:1];

    logic [NCH-1:0][4:0]       ctl_q, ctl_d;
    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0][CNT_W-1:0] msk;
    logic [NCH-1:0]            clk_en_q, clk_en_d;
    logic [RST_SYNC-1:0]       por_s_q, por_s_d;
    logic [NCH-1:0]            hit;
    logic [NCH-1:0]            wr;
    logic [NCH-1:0]            src;
    logic [15:0]               dout;
    logic                      lfxt_tick;
    logic                      unused_din;

    assign unused_din = ^{per.per_din[15:13], per.per_din[7:5]};

`ifdef OMSP_CLKGEN_LFXT_EN
    logic [2:0] lfxt_s_q, lfxt_s_d;

    assign lfxt_s_d  = {lfxt_s_q[1:0], lfxt_clk};
    assign lfxt_tick = lfxt_s_q[1] & ~lfxt_s_q[2] & ~oscoff;

    always_ff @(posedge mclk or posedge por_reset_a) begin
        if (por_reset_a) lfxt_s_q <= '0;
        else             lfxt_s_q <= lfxt_s_d;
    end
`else
    logic unused_lfxt;

    assign unused_lfxt = lfxt_clk ^ oscoff;
    assign lfxt_tick   = 1'b0;
`endif

    always_comb begin
        hit = '0;
        wr  = '0;
        src = '0;
        for (int i = 0; i < NCH; i++) begin
            hit[i] = per.per_en & (per.per_addr == BASE_W + 8'(i / 2));
            wr[i]  = hit[i] & per.per_we[i % 2];
            src[i] = ctl_q[i][4] & ~gate[i]
                   & (ctl_q[i][3] ? lfxt_tick : 1'b1);
        end
    end

    // Low DIV bits of the count; bits past CNT_W do not exist, which clamps.
    always_comb begin
        msk = '0;
        for (int i = 0; i < NCH; i++)
            for (int b = 0; b < CNT_W; b++)
                if (b < int'(ctl_q[i][2:0])) msk[i][b] = 1'b1;
    end

    always_comb begin
        ctl_d    = ctl_q;
        cnt_d    = cnt_q;
        clk_en_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr[i]) begin
                ctl_d[i] = per.per_din[(i % 2) * 8 +: 5] & CTL_MASK;
                cnt_d[i] = '0;
            end else if (src[i]) begin
                clk_en_d[i] = (cnt_q[i] & msk[i]) == msk[i];
                if (|msk[i]) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        dout = '0;
        if (per.per_we == 2'b00)
            for (int i = 0; i < NCH; i++)
                if (hit[i]) dout[(i % 2) * 8 +: 8] = {3'b000, ctl_q[i]};
    end

    assign per.per_dout = dout;

    assign por_s_d = {por_s_q[RST_SYNC-2:0], 1'b0};

    always_ff @(posedge mclk or posedge por_reset_a) begin
        if (por_reset_a) begin
            ctl_q    <= {NCH{5'h10}};
            cnt_q    <= '0;
            clk_en_q <= '0;
            por_s_q  <= '1;
        end else begin
            ctl_q    <= ctl_d;
            cnt_q    <= cnt_d;
            clk_en_q <= clk_en_d;
            por_s_q  <= por_s_d;
        end
    end

    assign clk_en = clk_en_q;
    assign por    = por_s_q[RST_SYNC-1];

endmodule

// File: tb/tb_omsp_clk_en_gen.sv
// Scoreboard bench for omsp_clk_en_gen: two instances (CNT_W 7 and 2)
// share one bus and gate vector; a cycle model feeds the expect queue.
`timescale 1ns/1ps
module tb_omsp_clk_en_gen;
    localparam int CW0 = 7;
    localparam int CW1 = 2;
`ifdef OMSP_CLKGEN_LFXT_EN
    localparam logic [4:0] MSK = 5'h1f;
`else
    localparam logic [4:0] MSK = 5'h17;
`endif

    logic       mclk = 1'b0;
    logic       por_reset_a = 1'b1;
    logic       lfxt_clk = 1'b0;
    logic       oscoff = 1'b0;
    logic [1:0] gate = 2'b00;
    logic [1:0] clk_en0, clk_en1;
    logic       por0, por1;

    omsp_clk_en_gen_if bus0 ();
    omsp_clk_en_gen_if bus1 ();

    assign bus1.per_addr = bus0.per_addr;
    assign bus1.per_din  = bus0.per_din;
    assign bus1.per_en   = bus0.per_en;
    assign bus1.per_we   = bus0.per_we;

    omsp_clk_en_gen #(.NCH(2), .CNT_W(CW0)) u_dut0 (
        .mclk(mclk), .por_reset_a(por_reset_a), .lfxt_clk(lfxt_clk),
        .oscoff(oscoff), .gate(gate), .per(bus0),
        .clk_en(clk_en0), .por(por0)
    );

    omsp_clk_en_gen #(.NCH(2), .CNT_W(CW1)) u_dut1 (
        .mclk(mclk), .por_reset_a(por_reset_a), .lfxt_clk(lfxt_clk),
        .oscoff(oscoff), .gate(gate), .per(bus1),
        .clk_en(clk_en1), .por(por1)
    );

    always #5 mclk = ~mclk;
    always #150 lfxt_clk = ~lfxt_clk;

    typedef struct {
        int         cyc;
        int         which;
        logic [1:0] exp;
        string      tag;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  cycnt = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    logic [4:0] m_ctl [2][2];
    int         m_tk [2][2];
    int         por_left;

    always @(posedge mclk) cycnt <= cycnt + 1;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge mclk) begin
        while (sb.size() > 0 && sb[0].cyc <= cycnt) begin
            mon_e = sb.pop_front();
            case (mon_e.which)
                0:       chk(mon_e.tag, {14'd0, clk_en0}, {14'd0, mon_e.exp});
                1:       chk(mon_e.tag, {14'd0, clk_en1}, {14'd0, mon_e.exp});
                default: chk(mon_e.tag, {14'd0, por1, por0}, {14'd0, mon_e.exp});
            endcase
        end
    end

    task automatic m_reset();
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 2; c++) begin
                m_ctl[d][c] = 5'h10;
                m_tk[d][c]  = 0;
            end
        por_left = 2;
    endtask

    // Model one mclk cycle with the inputs now driven, queue the result.
    task automatic tick_cyc(input string tag);
        logic [1:0] e;
        logic       w, s, skip;
        int         cw, dv, p;
        if (por_left > 0) por_left--;
        sb.push_back('{cyc: cycnt + 1, which: 2,
                       exp: {2{por_left > 0}}, tag: {tag, "/por"}});
        for (int d = 0; d < 2; d++) begin
            e    = 2'b00;
            skip = 1'b0;
            cw   = (d == 0) ? CW0 : CW1;
            for (int c = 0; c < 2; c++) begin
                w = bus0.per_en && bus0.per_addr == 8'h38 && bus0.per_we[c];
                if (w) begin
                    m_ctl[d][c] = (c == 1 ? bus0.per_din[12:8]
                                          : bus0.per_din[4:0]) & MSK;
                    m_tk[d][c]  = 0;
                end else begin
                    if (m_ctl[d][c][3]) skip = 1'b1;
                    s  = m_ctl[d][c][4] && !gate[c] && !m_ctl[d][c][3];
                    dv = int'(m_ctl[d][c][2:0]);
                    p  = 1 << ((dv > cw) ? cw : dv);
                    if (s) begin
                        m_tk[d][c]++;
                        e[c] = (m_tk[d][c] % p) == 0;
                    end
                end
            end
            if (!skip)
                sb.push_back('{cyc: cycnt + 1, which: d, exp: e,
                               tag: {tag, d == 0 ? "/u0" : "/u1"}});
        end
        @(posedge mclk);
        #1;
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) tick_cyc(tag);
    endtask

    task automatic wr_ctl(input int ch, input logic [7:0] v, input string tag);
        bus0.per_en   = 1'b1;
        bus0.per_addr = 8'h38;
        bus0.per_we   = (ch == 1) ? 2'b10 : 2'b01;
        bus0.per_din  = (ch == 1) ? {v, 8'h5a} : {8'ha5, v};
        tick_cyc(tag);
        bus0.per_en = 1'b0;
        bus0.per_we = 2'b00;
    endtask

    task automatic rd(input logic [7:0] a, input string tag);
        logic [15:0] e0, e1;
        e0 = '0;
        e1 = '0;
        if (a == 8'h38) begin
            e0 = {3'b000, m_ctl[0][1], 3'b000, m_ctl[0][0]};
            e1 = {3'b000, m_ctl[1][1], 3'b000, m_ctl[1][0]};
        end
        bus0.per_en   = 1'b1;
        bus0.per_we   = 2'b00;
        bus0.per_addr = a;
        #1;
        chk({tag, "/u0"}, bus0.per_dout, e0);
        chk({tag, "/u1"}, bus1.per_dout, e1);
        bus0.per_en = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 6 && sb.size() > 0; i++) @(negedge mclk);
        chk("sb_drain", 16'(sb.size()), 16'd0);
        @(posedge mclk);
        #1;
    endtask

    task automatic release_rst(input string tag);
        m_reset();
        por_reset_a = 1'b0;
        tick_cyc(tag);
        tick_cyc(tag);
        run(3, tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        bus0.per_en   = 1'b0;
        bus0.per_we   = 2'b00;
        bus0.per_addr = 8'h00;
        bus0.per_din  = 16'h0000;
        m_reset();
        repeat (3) @(posedge mclk);
        #1;
        chk("rst_clk_en0", {14'd0, clk_en0}, 16'd0);
        chk("rst_clk_en1", {14'd0, clk_en1}, 16'd0);
        chk("rst_por", {14'd0, por1, por0}, 16'h3);
        chk("rst_dout", bus0.per_dout, 16'h0000);

        release_rst("rel");
        bus0.per_en   = 1'b1;
        bus0.per_addr = 8'h38;
        #1;
        chk("rd_base_const", bus0.per_dout, 16'h1010);
        bus0.per_en = 1'b0;
        rd(8'h39, "rd_miss");

        wr_ctl(0, 8'h12, "div4_wr");
        run(15, "div4");
        wr_ctl(0, 8'h12, "coinc_wr");
        run(3, "gate_pre");
        gate = 2'b01;
        run(10, "gate_on");
        gate = 2'b00;
        run(8, "gate_off");
        rd(8'h38, "rd_div4");

        bus0.per_en   = 1'b1;
        bus0.per_addr = 8'h39;
        bus0.per_we   = 2'b11;
        bus0.per_din  = 16'hffff;
        tick_cyc("miss_wr");
        bus0.per_en = 1'b0;
        bus0.per_we = 2'b00;
        run(4, "miss_run");

        wr_ctl(0, 8'h17, "clamp_wr");
        run(140, "clamp");
        wr_ctl(1, 8'h11, "ch1_div2_wr");
        run(8, "ch1_div2");
        wr_ctl(0, 8'h02, "en0_wr");
        run(10, "en0");

        wr_ctl(1, 8'h18, "sel_wr");
`ifndef OMSP_CLKGEN_LFXT_EN
        run(6, "sel_off");
        bus0.per_en   = 1'b1;
        bus0.per_addr = 8'h38;
        #1;
        chk("sel_off_rd", {8'h00, bus0.per_dout[15:8]}, 16'h0010);
        bus0.per_en = 1'b0;
`else
        run(6, "sel_lfxt1");
        wr_ctl(1, 8'h19, "lfxt_wr");
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            tick_cyc("lfxt");
            if (clk_en0[1]) cnt++;
        end
        chk("lfxt_rate", 16'(cnt >= 32 && cnt <= 34), 16'd1);
        oscoff = 1'b1;
        run(3, "osc_settle");
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            tick_cyc("oscoff");
            if (clk_en0[1] || clk_en1[1]) cnt++;
        end
        chk("oscoff_cnt", 16'(cnt), 16'd0);
        oscoff = 1'b0;
`endif
        wr_ctl(1, 8'h10, "ch1_restore");
        run(4, "ch1_div1");
        rd(8'h38, "rd_final");

        drain();
        #3;
        por_reset_a = 1'b1;
        #1;
        chk("mid_rst_clk_en0", {14'd0, clk_en0}, 16'd0);
        chk("mid_rst_clk_en1", {14'd0, clk_en1}, 16'd0);
        chk("mid_rst_por", {14'd0, por1, por0}, 16'h3);
        @(posedge mclk);
        #1;
        release_rst("rel2");
        rd(8'h38, "rd_rel2");

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
